// File: rtl/memory_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : types
//  Description : Address map, region decode and bit positions for memory_bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package types;

    localparam logic [11:0] RAM_END       = 12'h27F;
    localparam logic [11:0] VRAM0_BASE    = 12'hE00;
    localparam logic [11:0] VRAM1_BASE    = 12'hE80;
    localparam logic [11:0] VRAM_BANK_LEN = 12'd80;
    localparam logic [11:0] IO_FACTOR     = 12'hF00;
    localparam logic [11:0] IO_MASK       = 12'hF10;
    localparam logic [11:0] IO_TM_LO      = 12'hF20;
    localparam logic [11:0] IO_TM_HI      = 12'hF21;
    localparam logic [11:0] IO_CTRL       = 12'hF76;

    localparam int IT1_BIT   = 3;
    localparam int IT2_BIT   = 2;
    localparam int IT8_BIT   = 1;
    localparam int IT32_BIT  = 0;
    localparam int TMRST_BIT = 1;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_VRAM,
        REGION_IO,
        REGION_NONE
    } mem_region;

    function automatic mem_region decode_region(input logic [11:0] addr);
        if (addr <= RAM_END)
            return REGION_RAM;
        if ((addr >= VRAM0_BASE && addr < VRAM0_BASE + VRAM_BANK_LEN) ||
            (addr >= VRAM1_BASE && addr < VRAM1_BASE + VRAM_BANK_LEN))
            return REGION_VRAM;
        if (addr[11:8] == 4'hF)
            return REGION_IO;
        return REGION_NONE;
    endfunction

    // The two 80-nibble display banks are packed back to back: 0..79, 80..159.
    function automatic logic [7:0] vram_index(input logic [7:0] addr_lo);
        return addr_lo[7] ? (8'd80 + {1'b0, addr_lo[6:0]}) : {1'b0, addr_lo[6:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_bus_clock_timer.sv
`default_nettype none
// ============================================================================
//  Module      : clock_timer
//  Description : 256 Hz clock timer: divider, 8-bit TM counter, IT factor flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_timer
    import types::*;
#(
    parameter int CLK_DIV = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_factor,
    input  logic       tm_reset,
    output logic [7:0] tm,
    output logic [3:0] factor,
    output logic       tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [7:0]       w_tm_next;
    logic [3:0]       w_set;

    assign tick      = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_tm_next = tm + 8'd1;

    // A timer reset on the tick cycle suppresses both the increment and the flags.
    always_comb begin
        w_set = 4'h0;
        if (tick && !tm_reset) begin
            w_set[IT32_BIT] = (w_tm_next[2:0] == 3'd0);
            w_set[IT8_BIT]  = (w_tm_next[4:0] == 5'd0);
            w_set[IT2_BIT]  = (w_tm_next[6:0] == 7'd0);
            w_set[IT1_BIT]  = (w_tm_next      == 8'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            tm     <= 8'd0;
            factor <= 4'h0;
        end else begin
            if (tm_reset) begin
                r_div <= '0;
                tm    <= 8'd0;
            end else begin
                r_div <= tick ? '0 : r_div + 1'b1;
                if (tick)
                    tm <= w_tm_next;
            end
            // New flags win over a same-cycle read-clear.
            factor <= (clear_factor ? 4'h0 : factor) | w_set;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_bus.sv
`default_nettype none
// ============================================================================
//  Module      : memory_bus
//  Description : CPU data-memory decode: work RAM, display RAM and timer I/O.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_bus
    import types::*;
#(
    parameter int CLK_DIV = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_write_en,
    input  logic        memory_read_en,
    input  logic [11:0] memory_addr,
    input  logic [3:0]  memory_write_data,
    output logic [3:0]  memory_read_data,
    input  logic [7:0]  video_addr,
    output logic [3:0]  video_data,
    output logic        interrupt_req
);

    logic [3:0] r_work_ram [0:639];
    logic [3:0] r_vram     [0:159];
    logic [3:0] r_mask;

    mem_region  w_region;
    logic [7:0] w_vram_idx;
    logic [9:0] w_ram_idx;
    logic       w_clear_factor;
    logic       w_tm_reset;
    logic [7:0] w_tm;
    logic [3:0] w_factor;
    logic       w_unused_tick;
    logic [3:0] w_read_next;
    logic [3:0] w_video_next;

    assign w_region       = decode_region(memory_addr);
    assign w_vram_idx     = vram_index(memory_addr[7:0]);
    assign w_ram_idx      = memory_addr[9:0];
    assign w_clear_factor = memory_read_en && (memory_addr == IO_FACTOR);
    assign w_tm_reset     = memory_write_en && (memory_addr == IO_CTRL) &&
                            memory_write_data[TMRST_BIT];

    clock_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_clock_timer (
        .clk          (clk),
        .reset        (reset),
        .clear_factor (w_clear_factor),
        .tm_reset     (w_tm_reset),
        .tm           (w_tm),
        .factor       (w_factor),
        .tick         (w_unused_tick)
    );

    // RAM contents survive reset; only the write strobe is blocked.
    always_ff @(posedge clk) begin
        if (!reset && memory_write_en) begin
            if (w_region == REGION_RAM)
                r_work_ram[w_ram_idx] <= memory_write_data;
            if (w_region == REGION_VRAM)
                r_vram[w_vram_idx] <= memory_write_data;
        end
    end

    always_comb begin
        w_read_next = 4'h0;
        case (w_region)
            REGION_RAM:  w_read_next = r_work_ram[w_ram_idx];
            REGION_VRAM: w_read_next = r_vram[w_vram_idx];
            REGION_IO: begin
                case (memory_addr)
                    IO_FACTOR: w_read_next = w_factor;
                    IO_MASK:   w_read_next = r_mask;
                    IO_TM_LO:  w_read_next = w_tm[3:0];
                    IO_TM_HI:  w_read_next = w_tm[7:4];
                    default:   w_read_next = 4'h0;
                endcase
            end
            default:     w_read_next = 4'h0;
        endcase
    end

    assign w_video_next = (video_addr < 8'd160) ? r_vram[video_addr] : 4'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memory_read_data <= 4'h0;
            video_data       <= 4'h0;
            interrupt_req    <= 1'b0;
            r_mask           <= 4'h0;
        end else begin
            memory_read_data <= w_read_next;
            video_data       <= w_video_next;
            interrupt_req    <= |(w_factor & r_mask);
            if (memory_write_en && (memory_addr == IO_MASK))
                r_mask <= memory_write_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_bus
//  Description : Directed self-checking bench for memory_bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bus;

    localparam int CLK_DIV = 128;

    logic        clk;
    logic        reset;
    logic        memory_write_en;
    logic        memory_read_en;
    logic [11:0] memory_addr;
    logic [3:0]  memory_write_data;
    logic [3:0]  memory_read_data;
    logic [7:0]  video_addr;
    logic [3:0]  video_data;
    logic        interrupt_req;

    int checks = 0;
    int errors = 0;

    memory_bus #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .memory_write_en   (memory_write_en),
        .memory_read_en    (memory_read_en),
        .memory_addr       (memory_addr),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data),
        .video_addr        (video_addr),
        .video_data        (video_data),
        .interrupt_req     (interrupt_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [11:0] addr, input logic [3:0] data);
        memory_addr       = addr;
        memory_write_data = data;
        memory_write_en   = 1'b1;
        cycles(1);
        memory_write_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] addr, output logic [3:0] data);
        memory_addr    = addr;
        memory_read_en = 1'b1;
        cycles(1);
        memory_read_en = 1'b0;
        data           = memory_read_data;
    endtask

    // Timer phase restarts: the first edge after this returns is edge 1.
    task automatic do_reset();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        if (memory_read_data !== 4'h0) begin
            errors++; $display("FAIL reset_read_data: got %h expected 0", memory_read_data);
        end
        checks++;
        if (video_data !== 4'h0) begin
            errors++; $display("FAIL reset_video_data: got %h expected 0", video_data);
        end
        checks++;
        if (interrupt_req !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b expected 0", interrupt_req);
        end
        checks++;
    endtask

    task automatic test_ram();
        logic [3:0] d;
        bus_write(12'h27F, 4'hA);
        bus_read(12'h27F, d);
        checks++;
        if (d !== 4'hA) begin errors++; $display("FAIL ram_last: got %h expected a", d); end
        bus_write(12'h280, 4'h5);
        bus_read(12'h280, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL ram_unmapped: got %h expected 0", d); end
        // Write and read the same address together: old data comes back.
        memory_addr = 12'h27F; memory_write_data = 4'h6;
        memory_write_en = 1'b1; memory_read_en = 1'b1;
        cycles(1);
        memory_write_en = 1'b0; memory_read_en = 1'b0;
        checks++;
        if (memory_read_data !== 4'hA) begin
            errors++; $display("FAIL ram_rw_same: got %h expected a", memory_read_data);
        end
        bus_read(12'h27F, d);
        checks++;
        if (d !== 4'h6) begin errors++; $display("FAIL ram_after_rw: got %h expected 6", d); end
        bus_write(12'h000, 4'h3);
        bus_read(12'h000, d);
        checks++;
        if (d !== 4'h3) begin errors++; $display("FAIL ram_first: got %h expected 3", d); end
    endtask

    task automatic test_vram();
        logic [3:0] d;
        bus_write(12'hE81, 4'h7);
        bus_write(12'hE4F, 4'h3);
        bus_write(12'hE50, 4'h9);
        video_addr = 8'd81;
        cycles(1);
        checks++;
        if (video_data !== 4'h7) begin errors++; $display("FAIL video_81: got %h expected 7", video_data); end
        video_addr = 8'd79;
        cycles(1);
        checks++;
        if (video_data !== 4'h3) begin errors++; $display("FAIL video_79: got %h expected 3", video_data); end
        video_addr = 8'd160;
        cycles(1);
        checks++;
        if (video_data !== 4'h0) begin errors++; $display("FAIL video_160: got %h expected 0", video_data); end
        bus_read(12'hE81, d);
        checks++;
        if (d !== 4'h7) begin errors++; $display("FAIL cpu_vram_e81: got %h expected 7", d); end
        bus_read(12'hE50, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL cpu_vram_gap: got %h expected 0", d); end
    endtask

    task automatic test_it32();
        logic [3:0] d;
        do_reset();
        cycles(1030);
        bus_read(12'hF20, d);
        checks++;
        if (d !== 4'h8) begin errors++; $display("FAIL it32_tm_lo: got %h expected 8", d); end
        bus_read(12'hF00, d);
        checks++;
        if (d !== 4'h1) begin errors++; $display("FAIL it32_factor: got %h expected 1", d); end
        bus_read(12'hF00, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL it32_cleared: got %h expected 0", d); end
    endtask

    task automatic test_all_flags();
        logic [3:0] d;
        do_reset();
        cycles(256 * CLK_DIV - 2);
        bus_read(12'hF21, d);
        checks++;
        if (d !== 4'hF) begin errors++; $display("FAIL tm_hi_255: got %h expected f", d); end
        // This read lands on the wrap edge, where all four flags set.
        bus_read(12'hF00, d);
        checks++;
        if (d !== 4'h7) begin errors++; $display("FAIL factor_old_on_set: got %h expected 7", d); end
        bus_read(12'hF00, d);
        checks++;
        if (d !== 4'hF) begin errors++; $display("FAIL factor_all_set: got %h expected f", d); end
        bus_read(12'hF21, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL tm_hi_wrapped: got %h expected 0", d); end
    endtask

    task automatic test_irq();
        logic [3:0] d;
        do_reset();
        bus_write(12'hF10, 4'h1);
        cycles(1022);
        checks++;
        if (interrupt_req !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", interrupt_req); end
        cycles(1);
        checks++;
        if (interrupt_req !== 1'b0) begin errors++; $display("FAIL irq_on_set: got %b expected 0", interrupt_req); end
        cycles(1);
        checks++;
        if (interrupt_req !== 1'b1) begin errors++; $display("FAIL irq_after_set: got %b expected 1", interrupt_req); end
        bus_read(12'hF00, d);
        checks++;
        if (interrupt_req !== 1'b1) begin errors++; $display("FAIL irq_on_clear: got %b expected 1", interrupt_req); end
        cycles(1);
        checks++;
        if (interrupt_req !== 1'b0) begin errors++; $display("FAIL irq_after_clear: got %b expected 0", interrupt_req); end
        bus_read(12'hF10, d);
        checks++;
        if (d !== 4'h1) begin errors++; $display("FAIL mask_readback: got %h expected 1", d); end
    endtask

    task automatic test_tmrst();
        logic [3:0] d;
        do_reset();
        cycles(1023);
        bus_write(12'hF76, 4'h2);
        bus_read(12'hF00, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL tmrst_factor: got %h expected 0", d); end
        bus_read(12'hF20, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL tmrst_tm: got %h expected 0", d); end
        cycles(125);
        bus_read(12'hF20, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL tmrst_before_tick: got %h expected 0", d); end
        bus_read(12'hF20, d);
        checks++;
        if (d !== 4'h1) begin errors++; $display("FAIL tmrst_first_tick: got %h expected 1", d); end
    endtask

    task automatic test_async_reset();
        logic [3:0] d;
        do_reset();
        video_addr = 8'd81;
        bus_write(12'hF10, 4'hF);
        cycles(1029);
        bus_read(12'hF20, d);
        checks++;
        if (d !== 4'h8 || video_data !== 4'h7 || interrupt_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got rd=%h vd=%h irq=%b expected rd=8 vd=7 irq=1",
                     d, video_data, interrupt_req);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (memory_read_data !== 4'h0) begin
            errors++; $display("FAIL async_read_data: got %h expected 0", memory_read_data);
        end
        checks++;
        if (video_data !== 4'h0) begin
            errors++; $display("FAIL async_video_data: got %h expected 0", video_data);
        end
        checks++;
        if (interrupt_req !== 1'b0) begin
            errors++; $display("FAIL async_irq: got %b expected 0", interrupt_req);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_read(12'hF10, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL async_mask: got %h expected 0", d); end
        cycles(126);
        bus_read(12'hF20, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL async_before_tick: got %h expected 0", d); end
        bus_read(12'hF20, d);
        checks++;
        if (d !== 4'h1) begin errors++; $display("FAIL async_first_tick: got %h expected 1", d); end
    endtask

    initial begin
        reset             = 1'b1;
        memory_write_en   = 1'b0;
        memory_read_en    = 1'b0;
        memory_addr       = 12'h000;
        memory_write_data = 4'h0;
        video_addr        = 8'd0;
        cycles(2);
        test_reset();
        reset = 1'b0;
        cycles(1);
        test_ram();
        test_vram();
        test_it32();
        test_all_flags();
        test_irq();
        test_tmrst();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_bus.md
# memory_bus

Nibble-wide data-memory subsystem that sits directly downstream of the CPU's memory port and produces the `memory_read_data` nibble the CPU consumes. It decodes the 12-bit data address into work RAM, display RAM and a small I/O register window. The I/O window covers the 256 Hz clock timer, its interrupt factor flags and the interrupt mask. A second read-only port lets the LCD renderer scan display RAM without disturbing the CPU.

## Interface
Parameters:
- `CLK_DIV`, 128: `clk` cycles per timer tick; 32.768 kHz / 128 = 256 Hz.

Ports:
- `clk` in 1: system clock (CPU rate); all state changes on rising edge.
- `reset` in 1: asynchronous, active-high reset. One clock; reset asynchronous and active-high.
- `memory_write_en` in 1: CPU write strobe for the current cycle.
- `memory_read_en` in 1: CPU read strobe; qualifies read side effects.
- `memory_addr` in 12: CPU data address.
- `memory_write_data` in 4: CPU write nibble.
- `memory_read_data` out 4: registered read nibble to CPU.
- `video_addr` in 8: renderer display-RAM index, 0–159.
- `video_data` out 4: registered display-RAM nibble.
- `interrupt_req` out 1: level request, `|(factor & mask)`.

## Operation
Address map; anything unmapped reads 0 and ignores writes:
- 0x000–0x27F: work RAM, 640×4, read/write.
- 0xE00–0xE4F and 0xE80–0xECF: display RAM, 160×4.
  - Index = `addr[7]`·80 + `addr[6:0]`.
  - `video_addr` uses the same index; indices ≥160 read 0.
- 0xF00: interrupt factor, read-only.
  - Bits: 3 = IT1, 2 = IT2, 1 = IT8, 0 = IT32.
  - A read with `memory_read_en` clears all four bits.
- 0xF10: interrupt mask, read/write, same bit order.
- 0xF20: TM[3:0], read-only.
- 0xF21: TM[7:4], read-only.
- 0xF76: control.
  - Writing 1 to bit 1 (TMRST) zeroes TM and the divider.
  - Reads return 0.

Clock timer:
- The divider counts 0..CLK_DIV-1. On wrap it emits a one-cycle tick.
- Each tick does TM ← TM+1, mod 256.
- Flags set on the tick that wraps these fields to zero:
  - IT32: TM[2:0]
  - IT8: TM[4:0]
  - IT2: TM[6:0]
  - IT1: all of TM (0xFF→0x00)

Simultaneous events:
- A flag set and a factor-register read-clear in the same cycle leave the flag **set**; the read data shows the old value.
- A TMRST write and a tick in the same cycle: TMRST wins. TM = 0, and no flags are set.
- A write and a read to the same address in one cycle: read data returns the **old** value.
- `memory_write_en` and `memory_read_en` are independent; both may be high.

## Timing
- Writes commit on the rising edge where `memory_write_en` is high.
- `memory_read_data` updates every cycle from the address sampled on the prior edge, giving 1-cycle latency. This holds whether or not `memory_read_en` is high; the strobe only gates the clear side effect.
- `video_data` has the same 1-cycle latency.
- `interrupt_req` is registered: it asserts the cycle after a flag sets with its mask bit set, and drops the cycle after the clear.

Reset values:
- Outputs `memory_read_data`, `video_data` and `interrupt_req` reset to 0.
- Internal state (TM, divider, factor flags, mask) resets to 0.
- RAM contents are not reset. Writes and clears are ignored while `reset` is high.
- Reset mid-count discards the partial divider count. The first tick after release comes CLK_DIV cycles later.

## Structure
- Shared package `types`, holding:
  - address range constants: RAM_END, VRAM0_BASE, VRAM1_BASE, IO_FACTOR, IO_MASK, IO_TM_LO, IO_TM_HI, IO_CTRL;
  - typedef `mem_region` {REGION_RAM, REGION_VRAM, REGION_IO, REGION_NONE};
  - bit-position constants for the IT flags and TMRST.
- One sub-module `clock_timer`. It owns the divider, TM, the factor flags and TMRST handling. Its inputs are `clear_factor` and `tm_reset` pulses; its outputs are TM, the factor nibble and `tick`.
- Address decode, RAM arrays, mask register and read muxing stay in `memory_bus`.

## Test plan
- Write 0xA to 0x27F, then read it → 0xA one cycle later. Write 0x5 to 0x280, then read it → 0x0.
- Write 0x7 to 0xE81, set `video_addr`=81 → `video_data`=0x7 next cycle. Reading CPU address 0xE81 → 0x7.
- Run 8×CLK_DIV cycles from reset → factor reads 0x1 with IT32 set, then 0x0 on the next read. Run 256×CLK_DIV cycles → IT1, IT2, IT8 and IT32 all set.
- Mask = 0x1 and the IT32 event → `interrupt_req` high one cycle after the set. A factor read → low one cycle after the clear.
- TMRST write on the exact tick cycle → TM reads 0x00 and the factor is unchanged. A flag-set cycle coinciding with a factor read → read returns old, flag remains set.
- Assert `reset` asynchronously mid-count with mask = 0xF → all outputs 0 immediately; first tick CLK_DIV cycles after release.
